dl_write_seq: RTL and testbench

//  Write sequencer sitting directly upstream of a bank of DEPTH DL latch primitives (latch-based register file).

---
 rtl/dl_write_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_dl_write_seq.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_write_seq.sv
// dl_write_seq: write sequencer in front of a bank of DEPTH DL latches
// (a latch-based register file).
//
// A write request (address/data) is taken over a valid/ready handshake. The
// sequencer then runs setup -> gate pulse -> hold on the shared latch D bus
// and a one-hot gate vector. Every latch-facing output comes straight from a
// flop, so the latches never see a combinational glitch on G.
//
// Ports
//   CLK       in   clock, rising edge
//   RESET     in   synchronous, active-high reset (has priority over CE)
//   CE        in   clock enable; 0 freezes FSM, counter and all outputs
//   IN_VALID  in   write request valid
//   IN_READY  out  CE & (state == IDLE), combinational
//   IN_ADDR   in   target latch word (ADDR_W bits)
//   IN_DATA   in   write data (WIDTH bits)
//   LAT_D     out  shared D bus of the latch bank (registered)
//   LAT_G     out  one-hot gate, bit i drives G of word i (registered)
//   BUSY      out  1 whenever the FSM is not IDLE (registered)
//   ADDR_ERR  out  one-cycle pulse when an accepted address is >= DEPTH
//
// Optional feature, macro DL_WRSEQ_INIT_CLEAR_EN:
//   when defined, leaving reset starts a walk over words 0..DEPTH-1 that
//   writes INIT_VAL to each word with the normal setup/pulse/hold timing.
//   BUSY stays high and IN_READY low until the last hold completes. A reset
//   during the walk restarts it at word 0. Without the macro the FSM is IDLE
//   on the first cycle after reset.

module dl_write_seq #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter int               ADDR_W    = 2,
  parameter int               SETUP_CYC = 1,
  parameter int               PULSE_CYC = 1,
  parameter int               HOLD_CYC  = 1,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] IN_ADDR,
  input  logic [WIDTH-1:0]  IN_DATA,
  output logic [WIDTH-1:0]  LAT_D,
  output logic [DEPTH-1:0]  LAT_G,
  output logic              BUSY,
  output logic              ADDR_ERR
);

  // One down-counter serves every phase. It is loaded with (N-1) when a phase
  // is entered, and the phase ends on the edge where it reads zero.
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  // DEPTH held one bit wider than the address, so that DEPTH == 2**ADDR_W
  // still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

`ifdef DL_WRSEQ_INIT_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // S_CLEAR is the setup phase of a clear-walk word. PULSE and HOLD are
  // shared with normal writes. clr_q tells the HOLD exit which path it is on.
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               cnt_done;
  logic               accept;

  logic [WIDTH-1:0]   lat_d_d;
  logic [DEPTH-1:0]   gate_d;
  logic               busy_d;
  logic               err_d;

`ifdef DL_WRSEQ_INIT_CLEAR_EN
  logic               clr_q, clr_d;
`endif

  assign IN_READY = CE & (state_q == S_IDLE);
  assign accept   = IN_VALID & IN_READY;
  assign cnt_done = (cnt_q == '0);
  assign cnt_dec  = cnt_q - CNT_W'(1);

  // ---------------------------------------------------------------------
  // State register and all registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q   <= '0;
      LAT_G    <= '0;
      ADDR_ERR <= 1'b0;
      // If a gate is open at this edge, keep D for one more edge so the
      // latch sees G fall before D moves. The next reset edge clears D.
      if (LAT_G == '0)
        LAT_D <= '0;
`ifdef DL_WRSEQ_INIT_CLEAR_EN
      state_q  <= S_CLEAR;
      cnt_q    <= SETUP_LD;
      BUSY     <= 1'b1;
      clr_q    <= 1'b1;
`else
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      BUSY     <= 1'b0;
`endif
    end else if (CE) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      LAT_D    <= lat_d_d;
      LAT_G    <= gate_d;
      BUSY     <= busy_d;
      ADDR_ERR <= err_d;
`ifdef DL_WRSEQ_INIT_CLEAR_EN
      clr_q    <= clr_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Next state, counter and address
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
`ifdef DL_WRSEQ_INIT_CLEAR_EN
    clr_d   = clr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          addr_d  = IN_ADDR;
        end
      end
`ifdef DL_WRSEQ_INIT_CLEAR_EN
      S_CLEAR,
`endif
      S_SETUP: begin
        if (cnt_done) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d   = cnt_dec;
        end
      end
      S_PULSE: begin
        if (cnt_done) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d   = cnt_dec;
        end
      end
      S_HOLD: begin
        if (cnt_done) begin
`ifdef DL_WRSEQ_INIT_CLEAR_EN
          if (clr_q && (addr_q != LAST_ADDR)) begin
            state_d = S_CLEAR;
            cnt_d   = SETUP_LD;
            addr_d  = addr_q + ADDR_W'(1);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            clr_d   = 1'b0;
          end
`else
          state_d = S_IDLE;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d   = cnt_dec;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Next values of the registered outputs
  // ---------------------------------------------------------------------
  always_comb begin
    lat_d_d = LAT_D;
    err_d   = 1'b0;
    gate_d  = '0;
    busy_d  = (state_d != S_IDLE);

    // D moves only at accept. The FSM is in IDLE then, so no gate is open.
    if ((state_q == S_IDLE) && accept) begin
      lat_d_d = IN_DATA;
      err_d   = ({1'b0, IN_ADDR} >= DEPTH_X);
    end

`ifdef DL_WRSEQ_INIT_CLEAR_EN
    // The clear walk drives INIT_VAL during its setup phase. With
    // SETUP_CYC == 1 on the first word, D and G switch on the same edge.
    // The latch is transparent for the whole pulse, so it still settles
    // on INIT_VAL.
    if (state_q == S_CLEAR)
      lat_d_d = INIT_VAL;
`endif

    // The gate is high for exactly the PULSE state. An out-of-range address
    // matches no bit, so the write is dropped and the timing is unchanged.
    if (state_d == S_PULSE) begin
      for (int i = 0; i < DEPTH; i++)
        gate_d[i] = (addr_q == ADDR_W'(i));
    end
  end

endmodule

// File: tb/tb_dl_write_seq.sv
module tb_dl_write_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];

  // DUT A: default geometry
  logic       rst_a, ce_a, vld_a, rdy_a, busy_a, err_a;
  logic [1:0] addr_a;
  logic [7:0] din_a, d_a;
  logic [3:0] g_a;

  dl_write_seq #(.INIT_VAL(8'h3C)) u_a (
    .CLK(clk), .RESET(rst_a), .CE(ce_a), .IN_VALID(vld_a), .IN_READY(rdy_a),
    .IN_ADDR(addr_a), .IN_DATA(din_a), .LAT_D(d_a), .LAT_G(g_a),
    .BUSY(busy_a), .ADDR_ERR(err_a));

  // DUT B: 3 words, stretched timing
  logic       rst_b, ce_b, vld_b, rdy_b, busy_b, err_b;
  logic [1:0] addr_b;
  logic [7:0] din_b, d_b;
  logic [2:0] g_b;

  dl_write_seq #(.DEPTH(3), .ADDR_W(2), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)) u_b (
    .CLK(clk), .RESET(rst_b), .CE(ce_b), .IN_VALID(vld_b), .IN_READY(rdy_b),
    .IN_ADDR(addr_b), .IN_DATA(din_b), .LAT_D(d_b), .LAT_G(g_b),
    .BUSY(busy_b), .ADDR_ERR(err_b));

  // DL bank models (power-up content 0xFF) and expected contents
  logic [7:0] mem_a [4] = '{default: 8'hFF};
  logic [7:0] mem_b [3] = '{default: 8'hFF};
  logic [7:0] exp_a [4] = '{default: 8'hFF};
  logic [7:0] exp_b [3] = '{default: 8'hFF};

  logic [3:0] pg_a;
  logic [7:0] pd_a;
  logic [2:0] pg_b;
  logic [7:0] pd_b;
  int viol_a = 0;
  int viol_b = 0;

  // Transparent latches. D must not move while a gate was open at the
  // previous sample (this covers the edge where the gate falls).
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (g_a[i] === 1'b1) mem_a[i] <= d_a;
    for (int j = 0; j < 3; j++) if (g_b[j] === 1'b1) mem_b[j] <= d_b;
    if ((|pg_a) === 1'b1 && d_a !== pd_a) viol_a <= viol_a + 1;
    if ((|pg_b) === 1'b1 && d_b !== pd_b) viol_b <= viol_b + 1;
    pg_a <= g_a; pd_a <= d_a;
    pg_b <= g_b; pd_b <= d_b;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy_a(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (rdy_a === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_rdy_b(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (rdy_b === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1;
    tick(); tick();
    total++; if (g_a !== 4'h0)  begin bad++; $display("FAIL reset_g_a got %h want 0", g_a); end
    total++; if (d_a !== 8'h00) begin bad++; $display("FAIL reset_d_a got %h want 00", d_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL reset_err_a got %b want 0", err_a); end
    total++; if (g_b !== 3'h0)  begin bad++; $display("FAIL reset_g_b got %h want 0", g_b); end
    total++; if (d_b !== 8'h00) begin bad++; $display("FAIL reset_d_b got %h want 00", d_b); end
`ifndef DL_WRSEQ_INIT_CLEAR_EN
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
`endif
    rst_a = 1'b0; rst_b = 1'b0;
`ifndef DL_WRSEQ_INIT_CLEAR_EN
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_rdy_a got %b want 1", rdy_a); end
    total++; if (rdy_b !== 1'b1) begin bad++; $display("FAIL reset_rdy_b got %b want 1", rdy_b); end
`endif
  endtask

`ifdef DL_WRSEQ_INIT_CLEAR_EN
  task automatic test_init_clear;
    int n;
    bit ok;
    n = 0;
    while (rdy_a !== 1'b1 && n < 100) begin n++; tick(); end
    total++; if (n != 12) begin bad++; $display("FAIL clear_notready_cycles got %0d want 12", n); end
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = 8'h3C;
      total++; if (mem_a[i] !== exp_a[i]) begin bad++; $display("FAIL clear_word_a%0d got %h want %h", i, mem_a[i], exp_a[i]); end
    end
    wait_rdy_b(ok);
    total++; if (!ok) begin bad++; $display("FAIL clear_b_timeout got 0 want 1"); end
    for (int i = 0; i < 3; i++) begin
      exp_b[i] = 8'h00;
      total++; if (mem_b[i] !== exp_b[i]) begin bad++; $display("FAIL clear_word_b%0d got %h want %h", i, mem_b[i], exp_b[i]); end
    end
  endtask
`endif

  task automatic test_single_write;
    bit ok;
    int busy_cnt, g_cnt, g_first;
    logic [3:0] g_seen;
    wr_t w;
    wait_rdy_a(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_ready_timeout got 0 want 1"); end
    vld_a = 1'b1; addr_a = 2'd2; din_a = 8'hA5;
    q_a.push_back('{a: 2'd2, d: 8'hA5});
    tick();
    vld_a = 1'b0; addr_a = 2'd0; din_a = 8'h00;
    total++; if (d_a !== 8'hA5) begin bad++; $display("FAIL single_lat_d got %h want a5", d_a); end
    total++; if (g_a !== 4'h0)  begin bad++; $display("FAIL single_setup_g got %h want 0", g_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL single_err got %b want 0", err_a); end
    busy_cnt = (busy_a === 1'b1) ? 1 : 0;
    g_cnt = 0; g_first = -1; g_seen = 4'h0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (g_a !== 4'h0) begin
        g_cnt++;
        g_seen = g_a;
        if (g_first < 0) g_first = k;
      end
      if (busy_a === 1'b1) busy_cnt++;
    end
    total++; if (g_cnt != 1)     begin bad++; $display("FAIL single_gate_width got %0d want 1", g_cnt); end
    total++; if (g_first != 1)   begin bad++; $display("FAIL single_gate_start got %0d want 1", g_first); end
    total++; if (g_seen !== 4'b0100) begin bad++; $display("FAIL single_gate_value got %b want 0100", g_seen); end
    total++; if (busy_cnt != 3)  begin bad++; $display("FAIL single_busy_cycles got %0d want 3", busy_cnt); end
    w = q_a.pop_front();
    exp_a[w.a] = w.d;
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_a[i] !== exp_a[i]) begin bad++; $display("FAIL single_word%0d got %h want %h", i, mem_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] dat [3];
    int acc_cyc [3];
    int widths [$];
    int run, n_acc, viol0;
    bit ok;
    wr_t w;
    dat = '{8'h11, 8'h22, 8'h33};
    acc_cyc = '{-100, -100, -100};
    run = 0; n_acc = 0;
    wait_rdy_b(ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_ready_timeout got 0 want 1"); end
    viol0 = viol_b;
    vld_b = 1'b1; addr_b = 2'd0; din_b = dat[0];
    for (int c = 0; c < 60; c++) begin
      if (n_acc < 3 && rdy_b === 1'b1) begin
        acc_cyc[n_acc] = c;
        q_b.push_back('{a: 2'(n_acc), d: dat[n_acc]});
        n_acc++;
      end
      tick();
      if (n_acc < 3) begin addr_b = 2'(n_acc); din_b = dat[n_acc]; end
      else vld_b = 1'b0;
      if (g_b !== 3'h0) run++;
      else if (run > 0) begin widths.push_back(run); run = 0; end
      if (n_acc == 3 && busy_b === 1'b0 && run == 0) break;
    end
    vld_b = 1'b0;
    total++; if (n_acc != 3) begin bad++; $display("FAIL b2b_accepts got %0d want 3", n_acc); end
    total++; if (acc_cyc[1] - acc_cyc[0] != 7) begin bad++; $display("FAIL b2b_spacing01 got %0d want 7", acc_cyc[1] - acc_cyc[0]); end
    total++; if (acc_cyc[2] - acc_cyc[1] != 7) begin bad++; $display("FAIL b2b_spacing12 got %0d want 7", acc_cyc[2] - acc_cyc[1]); end
    total++; if (widths.size() != 3) begin bad++; $display("FAIL b2b_pulses got %0d want 3", widths.size()); end
    foreach (widths[i]) begin
      total++; if (widths[i] != 3) begin bad++; $display("FAIL b2b_width%0d got %0d want 3", i, widths[i]); end
    end
    total++; if (viol_b != viol0) begin bad++; $display("FAIL b2b_d_moved_under_gate got %0d want %0d", viol_b, viol0); end
    while (q_b.size() > 0) begin
      w = q_b.pop_front();
      if (w.a < 2'd3) exp_b[w.a] = w.d;
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_b[i] !== exp_b[i]) begin bad++; $display("FAIL b2b_word%0d got %h want %h", i, mem_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_addr_err;
    bit ok;
    int err_cnt, gate_cnt, busy_cnt;
    wr_t w;
    wait_rdy_b(ok);
    total++; if (!ok) begin bad++; $display("FAIL aerr_ready_timeout got 0 want 1"); end
    vld_b = 1'b1; addr_b = 2'd3; din_b = 8'h5A;
    q_b.push_back('{a: 2'd3, d: 8'h5A});
    tick();
    vld_b = 1'b0;
    total++; if (err_b !== 1'b1) begin bad++; $display("FAIL aerr_pulse got %b want 1", err_b); end
    err_cnt  = (err_b === 1'b1) ? 1 : 0;
    gate_cnt = (g_b !== 3'h0) ? 1 : 0;
    busy_cnt = (busy_b === 1'b1) ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (err_b === 1'b1) err_cnt++;
      if (g_b !== 3'h0) gate_cnt++;
      if (busy_b === 1'b1) busy_cnt++;
      else break;
    end
    total++; if (err_cnt != 1)  begin bad++; $display("FAIL aerr_err_cycles got %0d want 1", err_cnt); end
    total++; if (gate_cnt != 0) begin bad++; $display("FAIL aerr_gate_cycles got %0d want 0", gate_cnt); end
    total++; if (busy_cnt != 6) begin bad++; $display("FAIL aerr_busy_cycles got %0d want 6", busy_cnt); end
    total++; if (rdy_b !== 1'b1) begin bad++; $display("FAIL aerr_ready_back got %b want 1", rdy_b); end
    w = q_b.pop_front();
    if (w.a < 2'd3) exp_b[w.a] = w.d;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_b[i] !== exp_b[i]) begin bad++; $display("FAIL aerr_word%0d got %h want %h", i, mem_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_ce_stall;
    bit ok;
    int gh;
    wr_t w;
    wait_rdy_a(ok);
    total++; if (!ok) begin bad++; $display("FAIL ce_ready_timeout got 0 want 1"); end
    vld_a = 1'b1; addr_a = 2'd1; din_a = 8'hC3;
    q_a.push_back('{a: 2'd1, d: 8'hC3});
    tick();
    vld_a = 1'b0; din_a = 8'h00;
    tick();
    gh = (g_a !== 4'h0) ? 1 : 0;
    total++; if (g_a !== 4'b0010) begin bad++; $display("FAIL ce_gate_value got %b want 0010", g_a); end
    ce_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (g_a !== 4'h0) gh++;
    end
    ce_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (g_a !== 4'h0) gh++;
      if (busy_a === 1'b0) break;
    end
    total++; if (gh != 5) begin bad++; $display("FAIL ce_gate_stretch got %0d want 5", gh); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL ce_resume got busy=%b want 0", busy_a); end
    w = q_a.pop_front();
    exp_a[w.a] = w.d;
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_a[i] !== exp_a[i]) begin bad++; $display("FAIL ce_word%0d got %h want %h", i, mem_a[i], exp_a[i]); end
    end
    ce_a = 1'b0; #1;
    total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL ce_ready_gated got %b want 0", rdy_a); end
    ce_a = 1'b1; #1;
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL ce_ready_restored got %b want 1", rdy_a); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    wr_t w;
    wait_rdy_a(ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_ready_timeout got 0 want 1"); end
    vld_a = 1'b1; addr_a = 2'd3; din_a = 8'h96;
    q_a.push_back('{a: 2'd3, d: 8'h96});
    tick();
    vld_a = 1'b0; din_a = 8'h00;
    tick();
    total++; if (g_a !== 4'b1000) begin bad++; $display("FAIL rmid_gate got %b want 1000", g_a); end
    rst_a = 1'b1;
    tick();
    total++; if (g_a !== 4'h0)  begin bad++; $display("FAIL rmid_gate_drop got %h want 0", g_a); end
    total++; if (d_a !== 8'h96) begin bad++; $display("FAIL rmid_d_hold got %h want 96", d_a); end
    tick();
    total++; if (d_a !== 8'h00) begin bad++; $display("FAIL rmid_d_clear got %h want 00", d_a); end
    rst_a = 1'b0;
    w = q_a.pop_front();
    exp_a[w.a] = w.d;
`ifdef DL_WRSEQ_INIT_CLEAR_EN
    wait_rdy_a(ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_clear_timeout got 0 want 1"); end
    for (int i = 0; i < 4; i++) exp_a[i] = 8'h3C;
`else
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL rmid_ready_after got %b want 1", rdy_a); end
`endif
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_a[i] !== exp_a[i]) begin bad++; $display("FAIL rmid_word%0d got %h want %h", i, mem_a[i], exp_a[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; ce_a = 1'b1; vld_a = 1'b0; addr_a = 2'd0; din_a = 8'h00;
    rst_b = 1'b1; ce_b = 1'b1; vld_b = 1'b0; addr_b = 2'd0; din_b = 8'h00;
    test_reset();
`ifdef DL_WRSEQ_INIT_CLEAR_EN
    test_init_clear();
`endif
    test_single_write();
    test_back_to_back();
    test_addr_err();
    test_ce_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
